// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store access unit between the multicycle control unit
// and the data memory bus. It runs one word-aligned valid/ready transfer per
// request, builds byte enables and lane-replicated store data, and extends
// load data. It reports misaligned, illegal-size and bus-timeout faults.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  // A zero TIMEOUT_CYCLES turns the watchdog off. The last-count value wraps
  // in that case, but it is never used.
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;

  logic        reqAny;
  logic        reqIllegal;
  logic        reqMisaligned;
  logic [3:0]  beCalc;
  logic [31:0] wdataCalc;
  logic [31:0] laneData;
  logic [31:0] loadValue;

  // Classify the live request. An illegal size code takes precedence over
  // misalignment; a store with a load-only (unsigned) code is illegal.
  always_comb begin
    reqAny        = req_read | req_write;
    reqIllegal    = 1'b0;
    reqMisaligned = 1'b0;
    if (req_write) begin
      reqIllegal = funct3[2] | (funct3 == 3'b011);
    end else begin
      reqIllegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    end
    if (funct3[1:0] == 2'b01) begin
      reqMisaligned = addr[0];
    end else if (funct3[1:0] == 2'b10) begin
      reqMisaligned = (addr[1:0] != 2'b00);
    end
  end

  // Byte enables, replicated store data and extended load data, all taken
  // from the request captured in IDLE so the bus stays stable during waits.
  always_comb begin
    beCalc    = 4'b1111;
    wdataCalc = wdata_q;
    laneData  = mem_rdata >> {addr_q[1:0], 3'b000};
    loadValue = laneData;
    case (funct3_q[1:0])
      2'b00: begin
        beCalc    = 4'b0001 << addr_q[1:0];
        wdataCalc = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        beCalc    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdataCalc = {2{wdata_q[15:0]}};
      end
      default: begin
        beCalc    = 4'b1111;
        wdataCalc = wdata_q;
      end
    endcase
    case (funct3_q)
      3'b000:  loadValue = {{24{laneData[7]}}, laneData[7:0]};
      3'b001:  loadValue = {{16{laneData[15]}}, laneData[15:0]};
      3'b100:  loadValue = {24'd0, laneData[7:0]};
      3'b101:  loadValue = {16'd0, laneData[15:0]};
      default: loadValue = laneData;
    endcase
  end

  // Next-state logic: capture and check the request in IDLE, wait for the
  // bus or the watchdog in ACCESS, and pulse completion for one RESP cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (reqAny) begin
          addr_d   = addr;
          funct3_d = funct3;
          wdata_d  = wdata;
          we_d     = req_write;
          cnt_d    = 32'd0;
          if (reqIllegal) begin
            fault_d = FAULT_ILLEGAL;
            state_d = RESP;
          end else if (reqMisaligned) begin
            fault_d = FAULT_MISALIGN;
            state_d = RESP;
          end else begin
            fault_d = FAULT_OK;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          fault_d = FAULT_OK;
          if (!we_q) begin
            rdata_d = loadValue;
          end
          state_d = RESP;
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
          fault_d = FAULT_TIMEOUT;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-request registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      fault_q  <= FAULT_OK;
      rdata_q  <= 32'd0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode. Bus strobes exist only in ACCESS, so a reset mid-transfer
  // drops them at once; busy stalls the control unit until RESP.
  always_comb begin
    mem_valid = (state_q == ACCESS);
    mem_we    = (state_q == ACCESS) & we_q;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_be    = (state_q == ACCESS) ? beCalc : 4'b0000;
    mem_wdata = ((state_q == ACCESS) && we_q) ? wdataCalc : 32'd0;
    done      = (state_q == RESP);
    fault     = fault_q;
    rdata     = rdata_q;
    busy      = ((state_q == IDLE) & reqAny) | (state_q == ACCESS);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads of every size,
// stores with wait states, alignment and size faults, bus timeout and a
// reset pulse in the middle of a transfer.
module tb_mem_access_unit;

  logic        clk;
  logic        resetn;
  logic        req_read;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int passCount  = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_read  (req_read),
    .req_write (req_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  // Free-running 10 ns clock; the design acts on the rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one request onto the control-unit side.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    req_read  = rd;
    req_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  // Issue one access from a falling edge and act as the bus: mem_ready rises
  // after readyDelay wait cycles. Latency counts cycles from the sampling
  // edge to the cycle where done is seen.
  task automatic runAccess(input string tag, input logic isWrite, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int readyDelay, input logic [31:0] busData,
                           input int expLatency, input logic [1:0] expFault,
                           input logic [31:0] expRdata, input logic [3:0] expBe,
                           input logic [31:0] expWdata, input int expValidCycles);
    int  lat;
    int  validCycles;
    bit  gotDone;
    lat         = 0;
    validCycles = 0;
    gotDone     = 1'b0;
    applyStimulus(!isWrite, isWrite, f3, a, wd);
    mem_ready = 1'b0;
    mem_rdata = busData;
    #1;
    checkOutput({tag, " busy on request"}, 32'(busy), 32'd1);
    while (!gotDone && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_valid) begin
        validCycles++;
        checkOutput({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
        checkOutput({tag, " mem_be"}, 32'(mem_be), 32'(expBe));
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(isWrite));
        checkOutput({tag, " mem_wdata"}, mem_wdata, expWdata);
        checkOutput({tag, " busy in access"}, 32'(busy), 32'd1);
        mem_ready = (validCycles > readyDelay);
      end
      if (done) begin
        gotDone = 1'b1;
        checkOutput({tag, " fault"}, 32'(fault), 32'(expFault));
        checkOutput({tag, " rdata"}, rdata, expRdata);
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLatency));
        checkOutput({tag, " valid cycles"}, 32'(validCycles), 32'(expValidCycles));
        checkOutput({tag, " valid dropped"}, 32'(mem_valid), 32'd0);
        checkOutput({tag, " busy in resp"}, 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        mem_ready = 1'b0;
      end
    end
    if (!gotDone) begin
      checkOutput({tag, " done within bound"}, 32'd0, 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      mem_ready = 1'b0;
    end
    @(negedge clk);
    checkOutput({tag, " done is one pulse"}, 32'(done), 32'd0);
    checkOutput({tag, " idle not busy"}, 32'(busy), 32'd0);
  endtask

  // Directed sequence of accesses with hand-computed expectations.
  initial begin
    resetn    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset fault", 32'(fault), 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_be", 32'(mem_be), 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    runAccess("LW 0x100", 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h8899AABB,
              2, 2'b00, 32'h8899AABB, 4'b1111, 32'h0, 1);
    runAccess("LB 0x103", 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF1234,
              2, 2'b00, 32'hFFFFFF80, 4'b1000, 32'h0, 1);
    runAccess("LBU 0x103", 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF1234,
              2, 2'b00, 32'h00000080, 4'b1000, 32'h0, 1);
    runAccess("LH 0x102", 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80011234,
              2, 2'b00, 32'hFFFF8001, 4'b1100, 32'h0, 1);
    runAccess("LHU 0x102", 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80011234,
              2, 2'b00, 32'h00008001, 4'b1100, 32'h0, 1);
    runAccess("SH 0x202", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'hFFFFFFFF,
              5, 2'b00, 32'h00008001, 4'b1100, 32'hABCDABCD, 4);
    runAccess("SB 0x201", 1'b1, 3'b000, 32'h201, 32'h0000005A, 0, 32'h0,
              2, 2'b00, 32'h00008001, 4'b0010, 32'h5A5A5A5A, 1);
    runAccess("SW 0x300", 1'b1, 3'b010, 32'h300, 32'hDEADBEEF, 1, 32'h0,
              3, 2'b00, 32'h00008001, 4'b1111, 32'hDEADBEEF, 2);
    runAccess("LW 0x101 misaligned", 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h12345678,
              1, 2'b01, 32'h00008001, 4'b0000, 32'h0, 0);
    runAccess("load f3=110", 1'b0, 3'b110, 32'h100, 32'h0, 0, 32'h12345678,
              1, 2'b10, 32'h00008001, 4'b0000, 32'h0, 0);
    runAccess("store f3=011 misaligned", 1'b1, 3'b011, 32'h001, 32'h0, 0, 32'h0,
              1, 2'b10, 32'h00008001, 4'b0000, 32'h0, 0);
    runAccess("store f3=100", 1'b1, 3'b100, 32'h000, 32'h0, 0, 32'h0,
              1, 2'b10, 32'h00008001, 4'b0000, 32'h0, 0);
    runAccess("LW timeout", 1'b0, 3'b010, 32'h104, 32'h0, 99, 32'hCAFEF00D,
              5, 2'b11, 32'h00008001, 4'b1111, 32'h0, 4);

    // Reset pulse while a load waits on the bus.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h180, 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset mem_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    checkOutput("mid reset mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset done", 32'(done), 32'd0);
    checkOutput("mid reset rdata", rdata, 32'd0);
    checkOutput("mid reset mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    runAccess("LW after reset", 1'b0, 3'b010, 32'h180, 32'h0, 1, 32'h11223344,
              3, 2'b00, 32'h11223344, 4'b1111, 32'h0, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit between the multicycle control unit and the external data memory bus. It accepts one read or write request per access, qualified by the RISC-V `funct3` size/sign code. It drives a word-aligned valid/ready bus transaction with byte enables and lane-replicated write data, and returns sign- or zero-extended load data. It stalls the control unit with `busy` until the access completes, and reports misalignment, illegal-size and bus-timeout faults.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles waiting for `mem_ready`; 0 disables the timeout.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_read` in 1: load request, held until `done`.
- `req_write` in 1: store request, held until `done`; wins if asserted together with `req_read`.
- `funct3` in 3: size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in 32: byte address.
- `wdata` in 32: store data (rs2).
- `busy` out 1: stall to the control unit.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result, held until the next successful load.
- `fault` out 2: 00 ok, 01 misaligned, 10 illegal `funct3`, 11 timeout; valid while `done`=1.
- `mem_valid` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: bus accepts or completes the transfer.
- `mem_rdata` in 32: bus read data, valid with `mem_ready` on reads.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On `req_read|req_write`, capture `addr`, `funct3`, `wdata` and the op (write if `req_write`) into internal registers.
  - Legal and aligned request: go to ACCESS.
  - Otherwise: go to RESP with the fault code latched; no bus transaction.
- Illegal `funct3`:
  - Loads: 011, 110, 111.
  - Stores: any value with `funct3[2]`=1, or 011.
  - Illegal takes precedence over misaligned.
- Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
- ACCESS:
  - Bus outputs are driven from the captured registers.
  - `mem_valid`=1 for every ACCESS cycle; outputs are held stable until `mem_ready`.
  - `mem_valid&mem_ready` at an edge: go to RESP with fault 00. On a load, `rdata` is registered from `mem_rdata` at that edge.
- Byte enables and write data:
  - B: `mem_be`=0001<<`addr[1:0]`; `mem_wdata`={4{`wdata[7:0]`}}.
  - H: `mem_be`=0011<<(2·`addr[1]`); `mem_wdata`={2{`wdata[15:0]`}}.
  - W: `mem_be`=1111; `mem_wdata`=`wdata`.
  - On loads, `mem_be` carries the same pattern and `mem_wdata` is 0.
- Load extraction:
  - The lane is `mem_rdata`>>(8·`addr[1:0]`).
  - B and H sign-extend bit 7 or bit 15; BU and HU zero-extend; W passes through.
- Timeout:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with `mem_ready`=0.
  - When the counter reaches `TIMEOUT_CYCLES`-1 with `mem_ready` still 0, go to RESP with fault 11 and drop `mem_valid`.
  - `rdata` is unchanged on timeout.
- RESP: `done`=1 and `fault` valid for one cycle, then return to IDLE.
- Faulted accesses never modify `rdata`.
- If a request is still asserted in IDLE after RESP, it is a new access. The requester must deassert it on the cycle following `done`.
- `busy` is combinational:
  - 1 in IDLE while a request is asserted.
  - 1 in ACCESS.
  - 0 in RESP and in idle-without-request.

## Timing
- Reset values (asynchronous, immediate on `resetn`=0):
  - State IDLE.
  - `mem_valid`, `mem_we`, `done`, `busy`-registers = 0.
  - `fault`=00, `rdata`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, timeout counter=0.
- Reset mid-ACCESS drops `mem_valid` immediately and abandons the transfer.
- Request sampled at edge E0: `mem_valid`=1 from cycle E0+1.
- With `mem_ready`=1 in the first ACCESS cycle, `done`=1 in cycle E0+2. Minimum latency is 2 cycles from request to `done`.
- Each extra wait cycle of `mem_ready`=0 adds one cycle.
- Faulted request (misaligned or illegal): `done`=1 with `fault` in cycle E0+1; `mem_valid` never asserts.
- Timeout: `done` with fault 11 in cycle E0+1+`TIMEOUT_CYCLES`.
- `mem_ready` while `mem_valid`=0 is ignored.

## Test plan
- LW at 0x100, bus returns 0x8899AABB with `mem_ready`=1 immediately -> `mem_addr`=0x100, `mem_be`=1111, `done` at E0+2, `rdata`=0x8899AABB, `fault`=00.
- LB at 0x103, then LBU at 0x103, `mem_rdata`=0x80FF1234 -> `mem_be`=1000; `rdata`=0xFFFFFF80, then 0x00000080.
- SH at 0x202, `wdata`=0x1234ABCD, `mem_ready` delayed 3 cycles -> `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCDABCD held stable 4 cycles, `busy` high throughout, `done` at E0+5.
- LW at 0x101 -> no `mem_valid`, `done` at E0+1, `fault`=01, `rdata` unchanged; `funct3`=110 load -> `fault`=10.
- `TIMEOUT_CYCLES`=4, `mem_ready` stuck 0 -> `mem_valid` for 4 cycles, then `done` with `fault`=11 at E0+5, `mem_valid` dropped.
- `resetn` pulsed low during ACCESS -> `mem_valid`, `busy`, `done` = 0 immediately, state IDLE; the next LW completes normally.
